simd_exec_pipe: RTL and testbench

SIMD_EXEC_PIPE -- requirements
Module: simd_exec_pipe

---
 rtl/simd_pkg.sv | 26 ++
 rtl/simd_lane_alu.sv | 79 +++++++
 rtl/simd_exec_pipe.sv | 96 +++++++++
 tb/tb_simd_exec_pipe.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared types for the SIMD execution pipe: opcodes, element sizes, lane width.
package simd_pkg;

  localparam int unsigned LANE_W = 64;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_ADDS   = 4'd2,
    OP_SUBS   = 4'd3,
    OP_MAX    = 4'd4,
    OP_MIN    = 4'd5,
    OP_AND    = 4'd6,
    OP_OR     = 4'd7,
    OP_XOR    = 4'd8,
    OP_POPCNT = 4'd9
  } op_t;

  typedef enum logic [1:0] {
    E8  = 2'b00,
    E16 = 2'b01,
    E32 = 2'b10,
    E64 = 2'b11
  } esize_t;

endpackage

// File: rtl/simd_lane_alu.sv
// Combinational ALU for one 64-bit lane; every element size is computed in
// parallel and the requested one is selected at the end.
module simd_lane_alu
  import simd_pkg::*;
(
  input  op_t                 op,
  input  esize_t              esize,
  input  logic [LANE_W-1:0]   rs1,
  input  logic [LANE_W-1:0]   rs2,
  output logic [LANE_W-1:0]   result_c,
  output logic                sat_c
);

  logic [LANE_W-1:0] size_res [4];
  logic [3:0]        size_sat;

  for (genvar s = 0; s < 4; s++) begin : g_size
    localparam int unsigned EW = 8 << s;
    localparam int unsigned NE = LANE_W / EW;

    logic [LANE_W-1:0] res;
    logic [NE-1:0]     clamp;

    for (genvar e = 0; e < NE; e++) begin : g_elem
      logic [EW-1:0] a, b, r;
      logic [EW:0]   wide;
      logic          c;

      assign a = rs1[e*EW +: EW];
      assign b = rs2[e*EW +: EW];

      // Saturating ops use a sign-extended EW+1 bit sum to spot overflow.
      always_comb begin
        r    = '0;
        c    = 1'b0;
        wide = '0;
        case (op)
          OP_ADD:  r = a + b;
          OP_SUB:  r = a - b;
          OP_ADDS, OP_SUBS: begin
            wide = (op == OP_ADDS) ? ({a[EW-1], a} + {b[EW-1], b})
                                   : ({a[EW-1], a} - {b[EW-1], b});
            if (wide[EW] != wide[EW-1]) begin
              c = 1'b1;
              r = wide[EW] ? {1'b1, {(EW-1){1'b0}}} : {1'b0, {(EW-1){1'b1}}};
            end else begin
              r = wide[EW-1:0];
            end
          end
          OP_MAX:    r = ($signed(a) > $signed(b)) ? a : b;
          OP_MIN:    r = ($signed(a) < $signed(b)) ? a : b;
          OP_AND:    r = a & b;
          OP_OR:     r = a | b;
          OP_XOR:    r = a ^ b;
          OP_POPCNT: r = EW'($countones(a));
          default:   r = '0;
        endcase
      end

      assign res[e*EW +: EW] = r;
      assign clamp[e]        = c;
    end

    assign size_res[s] = res;
    assign size_sat[s] = |clamp;
  end

  always_comb begin
    result_c = '0;
    sat_c    = 1'b0;
    case (esize)
      E8:  begin result_c = size_res[0]; sat_c = size_sat[0]; end
      E16: begin result_c = size_res[1]; sat_c = size_sat[1]; end
      E32: begin result_c = size_res[2]; sat_c = size_sat[2]; end
      E64: begin result_c = size_res[3]; sat_c = size_sat[3]; end
    endcase
  end

endmodule

// File: rtl/simd_exec_pipe.sv
// SIMD execute pipe: lane ALUs feed a STAGES-deep register pipeline that
// advances on a single global enable; also counts saturated results.
module simd_exec_pipe
  import simd_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  op_t               in_op,
  input  esize_t            in_esize,
  input  logic [DATA_W-1:0] in_rs1,
  input  logic [DATA_W-1:0] in_rs2,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_sat,
  input  logic              clr_sat,
  output logic [15:0]       sat_count
);

  localparam int unsigned N_LANES = DATA_W / LANE_W;
  localparam logic [15:0] SAT_MAX = 16'hFFFF;

  logic [DATA_W-1:0]  alu_result;
  logic [N_LANES-1:0] lane_sat;
  logic               en;
  logic               sat_xfer;

  logic               stage_valid  [STAGES];
  logic [DATA_W-1:0]  stage_result [STAGES];
  logic [TAG_W-1:0]   stage_tag    [STAGES];
  logic               stage_sat    [STAGES];

  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    simd_lane_alu u_alu (
      .op       (in_op),
      .esize    (in_esize),
      .rs1      (in_rs1[l*LANE_W +: LANE_W]),
      .rs2      (in_rs2[l*LANE_W +: LANE_W]),
      .result_c (alu_result[l*LANE_W +: LANE_W]),
      .sat_c    (lane_sat[l])
    );
  end

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Whole pipe shifts together; a stalled output freezes every stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_valid[i]  <= 1'b0;
        stage_result[i] <= '0;
        stage_tag[i]    <= '0;
        stage_sat[i]    <= 1'b0;
      end
    end else if (en) begin
      stage_valid[0]  <= in_valid;
      stage_result[0] <= alu_result;
      stage_tag[0]    <= in_tag;
      stage_sat[0]    <= |lane_sat;
      for (int i = 1; i < STAGES; i++) begin
        stage_valid[i]  <= stage_valid[i-1];
        stage_result[i] <= stage_result[i-1];
        stage_tag[i]    <= stage_tag[i-1];
        stage_sat[i]    <= stage_sat[i-1];
      end
    end
  end

  assign out_valid  = stage_valid[STAGES-1];
  assign out_result = stage_result[STAGES-1];
  assign out_tag    = stage_tag[STAGES-1];
  assign out_sat    = stage_sat[STAGES-1];

  assign sat_xfer = out_valid && out_ready && out_sat;

  // Clear wins over the count, but a coinciding saturated transfer still counts once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= '0;
    end else if (clr_sat) begin
      sat_count <= sat_xfer ? 16'd1 : 16'd0;
    end else if (sat_xfer && sat_count != SAT_MAX) begin
      sat_count <= sat_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_simd_exec_pipe.sv
// Directed bench for simd_exec_pipe (DATA_W=128, STAGES=2, TAG_W=5).
module tb_simd_exec_pipe;
  import simd_pkg::*;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  op_t          in_op;
  esize_t       in_esize;
  logic [127:0] in_rs1;
  logic [127:0] in_rs2;
  logic [4:0]   in_tag;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_result;
  logic [4:0]   out_tag;
  logic         out_sat;
  logic         clr_sat;
  logic [15:0]  sat_count;

  int n_pass  = 0;
  int n_total = 0;

  simd_exec_pipe #(.DATA_W(128), .STAGES(2), .TAG_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_esize   (in_esize),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_sat    (out_sat),
    .clr_sat    (clr_sat),
    .sat_count  (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input op_t op, input esize_t es, input logic [127:0] a,
                       input logic [127:0] b, input logic [4:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_esize = es;
    in_rs1   = a;
    in_rs2   = b;
    in_tag   = tag;
  endtask

  // Single op with out_ready high: absent after 1 cycle, present after 2, then transferred.
  task automatic run_one(input string name, input op_t op, input esize_t es,
                         input logic [127:0] a, input logic [127:0] b, input logic [4:0] tag,
                         input logic [127:0] exp_r, input logic exp_s, input logic clr);
    issue(op, es, a, b, tag);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check({name, "_early"}, out_valid, 1'b0);
    step();
    @(negedge clk);
    check({name, "_valid"}, out_valid, 1'b1);
    check({name, "_result"}, out_result, exp_r);
    check({name, "_sat"}, out_sat, exp_s);
    check({name, "_tag"}, out_tag, tag);
    clr_sat = clr;
    step();
    clr_sat = 1'b0;
  endtask

  initial begin
    logic [7:0]   t8;
    logic [127:0] bytes;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = OP_ADD;
    in_esize  = E8;
    in_rs1    = '0;
    in_rs2    = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    clr_sat   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_result", out_result, '0);
    check("rst_out_tag", out_tag, '0);
    check("rst_out_sat", out_sat, 1'b0);
    check("rst_sat_count", sat_count, '0);
    check("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    step();

    run_one("adds16", OP_ADDS, E16, {8{16'h7FFF}}, {8{16'h0001}}, 5'd3,
            {8{16'h7FFF}}, 1'b1, 1'b0);
    @(negedge clk);
    check("adds16_sat_count", sat_count, 16'd1);

    run_one("add32", OP_ADD, E32,
            128'hFFFFFFFF_00000010_00000000_FFFFFFFF,
            128'h00000001_00000020_00000000_00000001, 5'd4,
            128'h00000000_00000030_00000000_00000000, 1'b0, 1'b0);
    run_one("popcnt8", OP_POPCNT, E8,
            128'hFF7F3F1F0F070301_FF7F3F1F0F070301, '0, 5'd5,
            128'h0807060504030201_0807060504030201, 1'b0, 1'b0);
    run_one("subs8", OP_SUBS, E8, {16{8'h80}}, {16{8'h01}}, 5'd6,
            {16{8'h80}}, 1'b1, 1'b0);
    run_one("subs64", OP_SUBS, E64,
            128'h0000000000000000_000000000000000A,
            128'h0000000000000001_0000000000000003, 5'd7,
            128'hFFFFFFFFFFFFFFFF_0000000000000007, 1'b0, 1'b0);
    run_one("max16", OP_MAX, E16, {4{32'h8000_0005}}, {4{32'h0001_FFFF}}, 5'd8,
            {4{32'h0001_0005}}, 1'b0, 1'b0);
    run_one("min16", OP_MIN, E16, {4{32'h8000_0005}}, {4{32'h0001_FFFF}}, 5'd9,
            {4{32'h8000_FFFF}}, 1'b0, 1'b0);
    run_one("xor", OP_XOR, E32, {2{64'hF0F0_F0F0_0000_FFFF}}, {2{64'h0F0F_F0F0_FFFF_FFFF}},
            5'd10, {2{64'hFFFF_0000_FFFF_0000}}, 1'b0, 1'b0);
    run_one("undef_op", op_t'(4'hF), E8, {128{1'b1}}, {128{1'b1}}, 5'h1F,
            '0, 1'b0, 1'b0);
    @(negedge clk);
    check("sat_count_two", sat_count, 16'd2);
    step();

    // Four back-to-back ops: valid on cycles 2..5, tags 1..4 in order.
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        t8 = 8'(c + 1);
        bytes = {16{t8}};
        issue(OP_ADD, E8, bytes, '0, 5'(c + 1));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("b2b_valid", out_valid, (c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) begin
        t8 = 8'(c - 1);
        bytes = {16{t8}};
        check("b2b_tag", out_tag, 5'(c - 1));
        check("b2b_result", out_result, bytes);
      end
      step();
    end

    // Backpressure: pipe full of tags 6,7 while tag 8 waits at the input.
    out_ready = 1'b0;
    issue(OP_ADD, E8, {16{8'd6}}, '0, 5'd6);
    step();
    issue(OP_ADD, E8, {16{8'd7}}, '0, 5'd7);
    step();
    issue(OP_ADD, E8, {16{8'd8}}, '0, 5'd8);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_valid", out_valid, 1'b1);
      check("bp_tag", out_tag, 5'd6);
      check("bp_result", out_result, {16{8'd6}});
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", in_ready, 1'b1);
    check("bp_release_tag", out_tag, 5'd6);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_second_valid", out_valid, 1'b1);
    check("bp_second_tag", out_tag, 5'd7);
    step();
    @(negedge clk);
    check("bp_third_valid", out_valid, 1'b1);
    check("bp_third_tag", out_tag, 5'd8);
    check("bp_third_result", out_result, {16{8'd8}});
    step();
    @(negedge clk);
    check("bp_drained", out_valid, 1'b0);
    step();

    // Reset with two ops in flight: both are dropped at once.
    out_ready = 1'b0;
    issue(OP_ADD, E8, {16{8'd9}}, '0, 5'd9);
    step();
    issue(OP_ADD, E8, {16{8'd10}}, '0, 5'd10);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", out_valid, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_tag", out_tag, '0);
    check("mid_rst_result", out_result, '0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_no_emit", out_valid, 1'b0);
      step();
    end

    // sat_count: normal increment, clear coinciding with a saturated transfer, clear alone.
    run_one("post_rst_adds", OP_ADDS, E16, {8{16'h7FFF}}, {8{16'h0001}}, 5'd11,
            {8{16'h7FFF}}, 1'b1, 1'b0);
    @(negedge clk);
    check("sat_count_after_rst", sat_count, 16'd1);
    run_one("clr_adds", OP_ADDS, E8, {16{8'h7F}}, {16{8'h7F}}, 5'd12,
            {16{8'h7F}}, 1'b1, 1'b1);
    @(negedge clk);
    check("clr_with_sat", sat_count, 16'd1);
    clr_sat = 1'b1;
    step();
    clr_sat = 1'b0;
    @(negedge clk);
    check("clr_alone", sat_count, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
